stream_beat_packer: RTL and testbench
=====================================

// Module: stream_beat_packer
// PURPOSE
//   Sits directly downstream of the Compressor. Repacks its AXI-Stream output, whose beats carry
//   partial, LSB-aligned tkeep, into dense 32-byte beats. Only the final beat of a packet may be partial.
//   Byte order is preserved, and packet boundaries (tlast) are preserved exactly.
//   Feeds the DMA/egress side, which requires full beats except at end-of-packet.
// PARAMETERS
//   DATA_BYTES   32   bytes per beat; data width = 8*DATA_BYTES, keep width = DATA_BYTES
//   CNT_W        $clog2(2*DATA_BYTES+1) = 7   width of internal fill counter
// PORTS
//   clk         in   1     single clock; all logic on rising edge
//   reset_n     in   1     asynchronous, active-low reset
//   data_in     in   256   input beat; byte i = data_in[8i+7:8i]
//   tvalid_in   in   1     input beat valid
//   tlast_in    in   1     input beat ends packet
//   tkeep_in    in   32    input byte enables; expected contiguous from bit 0 (2^n-1, n=0..32)
//   tready_out  out  1     packer can accept input beat
//   data_out    out  256   packed output beat
//   tvalid_out  out  1     output beat valid
//   tlast_out   out  1     output beat ends packet
//   tkeep_out   out  32    output byte enables; 32'hFFFFFFFF unless tlast_out
//   tready_in   in   1     downstream accepts output beat
//   keep_err    out  1     sticky: non-contiguous tkeep_in seen on an accepted beat
// BEHAVIOUR
// - Reset (reset_n=0, async): buf cleared, fill=0, pend_last=0, keep_err=0.
//   Outputs: tvalid_out=0, tready_out=1, tlast_out=0, tkeep_out=0, data_out=0.
// - State: buf[2*DATA_BYTES bytes], fill (0..64 valid bytes, packed at buf byte 0), pend_last.
// - in_fire = tvalid_in & tready_out; out_fire = tvalid_out & tready_in.
// - n = byte count of an accepted beat = (index of highest set tkeep_in bit)+1; tkeep_in=0 -> n=0.
//   If the mask is non-contiguous: bytes below the top set bit are taken as-is and keep_err is set.
// - tready_out = !pend_last && fill <= 32. Registered-state only; no comb path from tready_in.
// - tvalid_out = (fill >= 32) || pend_last.
// - tlast_out = pend_last && fill <= 32.
// - tkeep_out = tlast_out ? (2^fill - 1) : all-ones.
// - data_out = buf bytes [31:0]. All outputs are driven from registers, giving 1-cycle input-to-output latency.
// - Per clock, applied in order:
//     1) on out_fire, shift buf down 32 bytes and set fill -= min(fill,32);
//        if tlast_out, clear pend_last.
//     2) on in_fire, write the n input bytes at byte offset fill (post-shift), set fill += n,
//        and set pend_last |= tlast_in.
//   A simultaneous out_fire and in_fire is legal; the input lands behind the remaining bytes.
// - Empty packet: tlast_in with tkeep_in=0 and fill=0 emits one beat with tkeep_out=0, tlast_out=1.
// - A tkeep_in=0 beat without tlast is consumed and produces nothing.
// - fill=64 at tlast: two output beats; only the second asserts tlast_out (tkeep all-ones).
// - Packet end: no new input is accepted until the last output beat fires. Packets never merge.
// - Backpressure: with tready_in=0, tvalid_out/data_out/tkeep_out/tlast_out hold stable (AXIS rule).
// - Reset mid-packet discards buffered bytes; the next beat after release starts a new packet.
// STRUCTURE
// - Shared package stream_pkg: DATA_BYTES, KEEP_W, the function keep_to_count(keep)->count,
//   the function count_to_keep(count)->mask, and the function keep_is_contig(keep).
//   Compressor reuses these.
// - One sub-module: stream_byte_shifter, combinational. Places n bytes at a byte offset in a 64-byte
//   window (barrel shift by offset). The top level holds the buffer, counters, handshake and flags.
// TESTING
// 1) After reset: tvalid_out=0, tready_out=1, keep_err=0.
//    Single beat: tkeep=FFFFFFFF, tlast=1, data=D -> one beat data=D, tkeep=FFFFFFFF, tlast=1.
// 2) Beats of 16+16 bytes: A (tkeep=0000FFFF), then B (tkeep=0000FFFF, tlast=1)
//    -> one beat {B[127:0],A[127:0]}, tkeep=FFFFFFFF, tlast=1.
// 3) 20B, 20B, 20B (tlast): beat 1 has 32 bytes, tlast=0; beat 2 has 28 bytes,
//    tkeep=0FFFFFFF, tlast=1. Bytes match the concatenation order.
// 4) tready_in=0 for 5 cycles while 64 bytes are buffered: tready_out=0 and outputs stay stable.
//    Release -> two full beats, the 2nd with tlast=1, then tready_out=1.
// 5) tkeep=0, tlast=1 with an empty buffer -> one beat with tkeep_out=0, tlast_out=1.
//    tkeep=0000F0FF on an accepted beat -> 16 bytes are taken and keep_err=1 stays set until reset.
// 6) Assert reset_n=0 mid-packet with 12 bytes buffered -> tvalid_out=0 immediately (async).
//    After release, a new 32B tlast beat emits clean with no stale bytes.

Source files
------------

// File: rtl/stream_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stream_pkg
// Description : Shared stream sizing constants and tkeep/count helper functions.
// Revision    : 1.0 - initial release
// ============================================================================
package stream_pkg;

    localparam int DATA_BYTES = 32;
    localparam int KEEP_W     = DATA_BYTES;
    localparam int DATA_W     = 8 * DATA_BYTES;
    localparam int CNT_W      = $clog2(2 * DATA_BYTES + 1);
    localparam int BEAT_CNT_W = $clog2(DATA_BYTES + 1);

    // Byte count implied by a mask: index of the highest set bit plus one.
    function automatic logic [BEAT_CNT_W-1:0] keep_to_count(input logic [KEEP_W-1:0] keep);
        logic [BEAT_CNT_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < KEEP_W; i++) begin
            if (keep[i]) begin
                cnt = BEAT_CNT_W'(i + 1);
            end
        end
        return cnt;
    endfunction

    function automatic logic [KEEP_W-1:0] count_to_keep(input logic [BEAT_CNT_W-1:0] count);
        logic [KEEP_W-1:0] mask;
        mask = '0;
        for (int i = 0; i < KEEP_W; i++) begin
            mask[i] = (BEAT_CNT_W'(i) < count);
        end
        return mask;
    endfunction

    // A dense LSB-aligned mask has no carry-chain overlap with itself plus one.
    function automatic logic keep_is_contig(input logic [KEEP_W-1:0] keep);
        return ((keep & (keep + KEEP_W'(1))) == '0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/stream_byte_shifter.sv
`default_nettype none
// ============================================================================
// Module      : stream_byte_shifter
// Description : Places count_i bytes of a beat at byte offset_i of a 2-beat window.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_byte_shifter
    import stream_pkg::*;
(
    input  logic [DATA_W-1:0]       data_i,
    input  logic [BEAT_CNT_W-1:0]   count_i,
    input  logic [CNT_W-1:0]        offset_i,
    output logic [2*DATA_W-1:0]     win_data_o,
    output logic [2*DATA_BYTES-1:0] win_en_o
);

    logic [2*DATA_W-1:0]     data_ext;
    logic [2*DATA_BYTES-1:0] en_ext;

    assign data_ext   = {{DATA_W{1'b0}}, data_i};
    assign en_ext     = {{DATA_BYTES{1'b0}}, count_to_keep(count_i)};

    assign win_data_o = data_ext << {offset_i, 3'b000};
    assign win_en_o   = en_ext << offset_i;

endmodule

`default_nettype wire

// File: rtl/stream_beat_packer.sv
`default_nettype none
// ============================================================================
// Module      : stream_beat_packer
// Description : Repacks partial LSB-aligned AXI-Stream beats into dense beats.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_beat_packer
    import stream_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_W-1:0]     data_in,
    input  logic                  tvalid_in,
    input  logic                  tlast_in,
    input  logic [KEEP_W-1:0]     tkeep_in,
    output logic                  tready_out,
    output logic [DATA_W-1:0]     data_out,
    output logic                  tvalid_out,
    output logic                  tlast_out,
    output logic [KEEP_W-1:0]     tkeep_out,
    input  logic                  tready_in,
    output logic                  keep_err
);

    localparam logic [CNT_W-1:0] BEAT_FILL = CNT_W'(DATA_BYTES);

    logic [2*DATA_W-1:0]     bytes_q, bytes_d;
    logic [CNT_W-1:0]        fill_q, fill_d;
    logic                    pend_last_q, pend_last_d;
    logic                    keep_err_q, keep_err_d;

    logic                    out_fire;
    logic                    in_fire;
    logic [BEAT_CNT_W-1:0]   in_count;
    logic [2*DATA_W-1:0]     bytes_shift;
    logic [CNT_W-1:0]        fill_shift;
    logic                    pend_shift;
    logic [2*DATA_W-1:0]     win_data;
    logic [2*DATA_BYTES-1:0] win_en;

    // Outputs are decoded from registered state only.
    assign tready_out = !pend_last_q && (fill_q <= BEAT_FILL);
    assign tvalid_out = (fill_q >= BEAT_FILL) || pend_last_q;
    assign tlast_out  = pend_last_q && (fill_q <= BEAT_FILL);
    assign tkeep_out  = !tvalid_out ? '0 :
                        tlast_out   ? count_to_keep(fill_q[BEAT_CNT_W-1:0]) : '1;
    assign data_out   = bytes_q[DATA_W-1:0];
    assign keep_err   = keep_err_q;

    assign out_fire   = tvalid_out && tready_in;
    assign in_fire    = tvalid_in && tready_out;
    assign in_count   = keep_to_count(tkeep_in);

    // Drain happens before the append so new bytes land behind what remains.
    assign bytes_shift = out_fire ? {{DATA_W{1'b0}}, bytes_q[2*DATA_W-1:DATA_W]} : bytes_q;
    assign fill_shift  = !out_fire            ? fill_q :
                         (fill_q >= BEAT_FILL) ? fill_q - BEAT_FILL : '0;
    assign pend_shift  = pend_last_q && !(out_fire && tlast_out);

    stream_byte_shifter u_shifter (
        .data_i     (data_in),
        .count_i    (in_count),
        .offset_i   (fill_shift),
        .win_data_o (win_data),
        .win_en_o   (win_en)
    );

    always_comb begin
        bytes_d     = bytes_shift;
        fill_d      = fill_shift;
        pend_last_d = pend_shift;
        keep_err_d  = keep_err_q;
        if (in_fire) begin
            for (int b = 0; b < 2*DATA_BYTES; b++) begin
                if (win_en[b]) begin
                    bytes_d[8*b +: 8] = win_data[8*b +: 8];
                end
            end
            fill_d      = fill_shift + CNT_W'(in_count);
            pend_last_d = pend_shift || tlast_in;
            if (!keep_is_contig(tkeep_in)) begin
                keep_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bytes_q     <= '0;
            fill_q      <= '0;
            pend_last_q <= 1'b0;
            keep_err_q  <= 1'b0;
        end else begin
            bytes_q     <= bytes_d;
            fill_q      <= fill_d;
            pend_last_q <= pend_last_d;
            keep_err_q  <= keep_err_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_stream_beat_packer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_stream_beat_packer
// Description : Self-checking bench for stream_beat_packer against a byte-queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_beat_packer;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [255:0] data_in;
    logic         tvalid_in;
    logic         tlast_in;
    logic [31:0]  tkeep_in;
    logic         tready_out;
    logic [255:0] data_out;
    logic         tvalid_out;
    logic         tlast_out;
    logic [31:0]  tkeep_out;
    logic         tready_in;
    logic         keep_err;

    always #5 clk = ~clk;

    stream_beat_packer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .data_in    (data_in),
        .tvalid_in  (tvalid_in),
        .tlast_in   (tlast_in),
        .tkeep_in   (tkeep_in),
        .tready_out (tready_out),
        .data_out   (data_out),
        .tvalid_out (tvalid_out),
        .tlast_out  (tlast_out),
        .tkeep_out  (tkeep_out),
        .tready_in  (tready_in),
        .keep_err   (keep_err)
    );

    typedef struct packed {
        logic [255:0] data;
        logic [31:0]  keep;
        logic         last;
    } beat_t;

    beat_t      exp_q[$];
    logic [7:0] acc_q[$];
    int         checks = 0;
    int         errors = 0;
    logic       err_exp = 1'b0;
    bit         held = 1'b0;
    beat_t      snap;
    bit         rand_ready = 1'b0;
    bit         in_fired = 1'b0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    function automatic void emit(input int k, input bit last);
        beat_t b;
        b.data = '0;
        b.keep = '0;
        b.last = last;
        for (int i = 0; i < k; i++) begin
            b.data[8*i +: 8] = acc_q.pop_front();
            b.keep[i] = 1'b1;
        end
        exp_q.push_back(b);
    endfunction

    // Reference: packet bytes accumulate in a queue; every 32 bytes form a beat,
    // and the packet end flushes whatever remains as a final (possibly empty) beat.
    function automatic void model_accept(input logic [255:0] d, input logic [31:0] k, input logic l);
        int n;
        logic [32:0] dense;
        n = 0;
        for (int i = 0; i < 32; i++) if (k[i]) n = i + 1;
        for (int i = 0; i < n; i++) acc_q.push_back(d[8*i +: 8]);
        dense = (33'h1 << n) - 33'h1;
        if ({1'b0, k} != dense) err_exp = 1'b1;
        while (acc_q.size() > 32 || (acc_q.size() == 32 && !l)) emit(32, 1'b0);
        if (l) emit(acc_q.size(), 1'b1);
    endfunction

    function automatic void model_reset();
        acc_q.delete();
        exp_q.delete();
        err_exp = 1'b0;
        held = 1'b0;
    endfunction

    // One clock: entered just after a falling edge, samples 1ns before the rising edge.
    task automatic cycle();
        beat_t b;
        bit of, inf;
        if (rand_ready) tready_in = ($urandom_range(0, 9) < 7);
        #4;
        of  = tvalid_out && tready_in;
        inf = tvalid_in && tready_out;
        chk("keep_err", keep_err, err_exp);
        if (held) begin
            chk("hold_valid", tvalid_out, 1'b1);
            chk("hold_data", data_out, snap.data);
            chk("hold_keep", tkeep_out, snap.keep);
            chk("hold_last", tlast_out, snap.last);
        end
        if (of) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL out_extra observed=beat_keep_%h expected=no_beat", tkeep_out);
            end
            if (exp_q.size() != 0) begin
                b = exp_q.pop_front();
                chk("out_data", data_out, b.data);
                chk("out_keep", tkeep_out, b.keep);
                chk("out_last", tlast_out, b.last);
            end
        end
        held = tvalid_out && !tready_in && reset_n;
        snap = {data_out, tkeep_out, tlast_out};
        if (inf) model_accept(data_in, tkeep_in, tlast_in);
        in_fired = inf;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_beat(input logic [255:0] d, input logic [31:0] k, input logic l);
        int t;
        t = 0;
        data_in = d; tkeep_in = k; tlast_in = l; tvalid_in = 1'b1;
        in_fired = 1'b0;
        while (!in_fired && t < 200) begin
            cycle();
            t++;
        end
        tvalid_in = 1'b0; data_in = '0; tkeep_in = '0; tlast_in = 1'b0;
        checks++;
        assert (in_fired) else begin
            errors++;
            $error("FAIL accept_timeout observed=stalled expected=accepted");
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((exp_q.size() != 0 || tvalid_out) && k < 300) begin
            cycle();
            k++;
        end
        checks++;
        assert (exp_q.size() == 0 && !tvalid_out) else begin
            errors++;
            $error("FAIL drain observed_left=%0d expected_left=0", exp_q.size());
        end
    endtask

    initial begin
        logic [255:0] a, b;
        logic [32:0]  m;
        logic [31:0]  k;
        int           n;

        reset_n = 1'b0; tvalid_in = 1'b0; tlast_in = 1'b0; tkeep_in = '0;
        data_in = '0; tready_in = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_tvalid", tvalid_out, 1'b0);
        chk("rst_tready", tready_out, 1'b1);
        chk("rst_keep_err", keep_err, 1'b0);
        chk("rst_tlast", tlast_out, 1'b0);
        chk("rst_tkeep", tkeep_out, 32'h0);
        chk("rst_data", data_out, 256'h0);
        reset_n = 1'b1;
        cycle();

        // Single full beat with tlast
        send_beat(rand256(), 32'hFFFF_FFFF, 1'b1);
        drain();

        // 16 + 16 bytes
        a = rand256(); b = rand256();
        send_beat(a, 32'h0000_FFFF, 1'b0);
        send_beat(b, 32'h0000_FFFF, 1'b1);
        drain();

        // 20 + 20 + 20 bytes
        for (int i = 0; i < 3; i++) send_beat(rand256(), 32'h000F_FFFF, i == 2);
        drain();

        // 64 bytes buffered under backpressure
        tready_in = 1'b0;
        send_beat(rand256(), 32'hFFFF_FFFF, 1'b0);
        send_beat(rand256(), 32'hFFFF_FFFF, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("bp_tready_out", tready_out, 1'b0);
            chk("bp_tvalid_out", tvalid_out, 1'b1);
        end
        tready_in = 1'b1;
        drain();
        chk("post_bp_tready", tready_out, 1'b1);

        // Empty packet, then a non-contiguous mask
        send_beat(rand256(), 32'h0, 1'b1);
        drain();
        send_beat(rand256(), 32'h0000_F0FF, 1'b0);
        send_beat(rand256(), 32'h0, 1'b1);
        drain();
        chk("keep_err_set", keep_err, 1'b1);
        cycle();
        chk("keep_err_sticky", keep_err, 1'b1);

        // Asynchronous reset with 12 bytes buffered
        send_beat(rand256(), 32'h0000_0FFF, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_tvalid", tvalid_out, 1'b0);
        chk("arst_data", data_out, 256'h0);
        chk("arst_keep_err", keep_err, 1'b0);
        chk("arst_tready", tready_out, 1'b1);
        model_reset();
        @(negedge clk);
        cycle();
        reset_n = 1'b1;
        send_beat(rand256(), 32'hFFFF_FFFF, 1'b1);
        drain();

        // Randomized traffic with random downstream backpressure
        rand_ready = 1'b1;
        for (int i = 0; i < 400; i++) begin
            n = $urandom_range(0, 32);
            m = (33'h1 << n) - 33'h1;
            k = m[31:0];
            if ($urandom_range(0, 15) == 0) k = $urandom;
            send_beat(rand256(), k, $urandom_range(0, 3) == 0);
            for (int g = $urandom_range(0, 2); g > 0; g--) cycle();
        end
        send_beat(rand256(), 32'h0000_00FF, 1'b1);
        drain();
        rand_ready = 1'b0;
        tready_in = 1'b1;
        cycle();
        chk("end_tready", tready_out, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
